// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared types and constants for the sprite pixel fetch stage.
// Slot 0 has the highest priority; TRANSPARENT marks an uncovered pixel.
package sprite_pkg;
    localparam int NUM_SPRITES = 8;
    localparam int SPR_W       = 32;
    localparam int SPR_H       = 32;
    localparam int ADDR_W      = 16;
    localparam int ID_W        = $clog2(NUM_SPRITES);

    typedef logic [ID_W-1:0] sprite_id_t;

    localparam logic [7:0] TRANSPARENT = 8'h00;

    localparam int SLOT_MARIO = 0;
    localparam int SLOT_LUIGI = 1;
    localparam int SLOT_FIRE0 = 2;
    localparam int SLOT_FIRE1 = 3;
    localparam int SLOT_PIPE  = 4;
    localparam int SLOT_ENEMY = 5;
    localparam int SLOT_ITEM  = 6;
    localparam int SLOT_FLAG  = 7;
endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// Sprite ROM bus: address out to the ROM, palette index back.
// The ROM returns data for rom_addr within the following Clk.
interface sprite_pixel_fetch_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_pixel_fetch_bbox_cmp.sv
// Per-slot bounding-box test, 11-bit so sprites near X=1023 clip
// instead of wrapping around to the left edge.
module sprite_bbox_cmp
    import sprite_pkg::*;
#(
    parameter int W = SPR_W,
    parameter int H = SPR_H
) (
    input  logic       en_i,
    input  logic [9:0] px_i,
    input  logic [9:0] py_i,
    input  logic [9:0] sx_i,
    input  logic [9:0] sy_i,
    output logic       hit_o,
    output logic [9:0] dx_o,
    output logic [9:0] dy_o
);
    localparam logic [10:0] W11 = 11'(W);
    localparam logic [10:0] H11 = 11'(H);

    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, sx_i} + W11;
    assign y_end = {1'b0, sy_i} + H11;

    assign hit_o = en_i
                && (px_i >= sx_i) && ({1'b0, px_i} < x_end)
                && (py_i >= sy_i) && ({1'b0, py_i} < y_end);

    assign dx_o = px_i - sx_i;
    assign dy_o = py_i - sy_i;
endmodule

// File: rtl/sprite_pixel_fetch.sv
// Sprite hit resolve + ROM fetch, 2-Clk latency, one pixel per Clk.
// Optional macro SPRITE_HFLIP_EN adds per-slot horizontal mirroring.
module sprite_pixel_fetch
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES,
    parameter int SPR_W       = sprite_pkg::SPR_W,
    parameter int SPR_H       = sprite_pkg::SPR_H,
    parameter int ADDR_W      = sprite_pkg::ADDR_W
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_clk,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [NUM_SPRITES*10-1:0]     spr_x,
    input  logic [NUM_SPRITES*10-1:0]     spr_y,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [NUM_SPRITES*ADDR_W-1:0] spr_base,
`ifdef SPRITE_HFLIP_EN
    input  logic [NUM_SPRITES-1:0]        spr_flip,
`endif
    sprite_pixel_fetch_if.master          rom,
    output logic [7:0]                    sprite_color,
    output logic                          sprite_hit,
    output logic [$clog2(NUM_SPRITES)-1:0] sprite_id,
    output logic [9:0]                    DrawX_d,
    output logic [9:0]                    DrawY_d
);
    localparam int IW = $clog2(NUM_SPRITES);
    localparam int SH = $clog2(SPR_W);

    logic [1:0]                    fsync_q;
    logic                          fprev_q;
    logic                          frame_edge;
    logic [NUM_SPRITES*10-1:0]     sh_x_q;
    logic [NUM_SPRITES*10-1:0]     sh_y_q;
    logic [NUM_SPRITES-1:0]        sh_en_q;
    logic [NUM_SPRITES*ADDR_W-1:0] sh_base_q;
    logic [NUM_SPRITES-1:0]        sh_flip_q;

    logic [NUM_SPRITES-1:0] hit_v;
    logic [9:0]             dx_v [NUM_SPRITES];
    logic [9:0]             dy_v [NUM_SPRITES];

    logic              win_hit;
    logic [IW-1:0]     win_id;
    logic [9:0]        win_dx;
    logic [9:0]        win_dy;
    logic [ADDR_W-1:0] win_base;
    logic              win_flip;
    logic [9:0]        dx_eff;
    logic [ADDR_W-1:0] rom_addr_d;

    logic              hit1_q;
    logic [IW-1:0]     id1_q;
    logic [9:0]        x1_q;
    logic [9:0]        y1_q;
    logic [ADDR_W-1:0] rom_addr_q;

    assign frame_edge = fsync_q[1] & ~fprev_q;

    // Synchronise frame_clk and keep last value for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync_q <= '0;
            fprev_q <= 1'b0;
        end else begin
            fsync_q <= {fsync_q[0], frame_clk};
            fprev_q <= fsync_q[1];
        end
    end

`ifdef SPRITE_HFLIP_EN
    // Shadow-latch flip bits together with the other slot state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_flip_q <= '0;
        end else if (frame_edge) begin
            sh_flip_q <= spr_flip;
        end
    end
`else
    assign sh_flip_q = '0;
`endif

    // Shadow-latch live sprite state once per frame to avoid tearing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_x_q    <= '0;
            sh_y_q    <= '0;
            sh_en_q   <= '0;
            sh_base_q <= '0;
        end else if (frame_edge) begin
            sh_x_q    <= spr_x;
            sh_y_q    <= spr_y;
            sh_en_q   <= spr_en;
            sh_base_q <= spr_base;
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cmp
        sprite_bbox_cmp #(.W(SPR_W), .H(SPR_H)) u_cmp (
            .en_i  (sh_en_q[g]),
            .px_i  (DrawX),
            .py_i  (DrawY),
            .sx_i  (sh_x_q[10*g +: 10]),
            .sy_i  (sh_y_q[10*g +: 10]),
            .hit_o (hit_v[g]),
            .dx_o  (dx_v[g]),
            .dy_o  (dy_v[g])
        );
    end

    // Priority pick: scan downward so the lowest hitting slot wins.
    always_comb begin
        win_hit  = 1'b0;
        win_id   = '0;
        win_dx   = '0;
        win_dy   = '0;
        win_base = '0;
        win_flip = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                win_hit  = 1'b1;
                win_id   = IW'(i);
                win_dx   = dx_v[i];
                win_dy   = dy_v[i];
                win_base = sh_base_q[ADDR_W*i +: ADDR_W];
                win_flip = sh_flip_q[i];
            end
        end
    end

    assign dx_eff = win_flip ? (10'(SPR_W - 1) - win_dx) : win_dx;
    assign rom_addr_d = win_base
                      + (ADDR_W'(win_dy) << SH)
                      + ADDR_W'(dx_eff);

    // Stage 1: register hit/id/coords; address only moves on a hit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit1_q     <= 1'b0;
            id1_q      <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            rom_addr_q <= '0;
        end else begin
            hit1_q <= win_hit;
            id1_q  <= win_id;
            x1_q   <= DrawX;
            y1_q   <= DrawY;
            if (win_hit) begin
                rom_addr_q <= rom_addr_d;
            end
        end
    end

    assign rom.rom_addr = rom_addr_q;

    // Stage 2: pick up ROM data and align outputs with coordinates.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sprite_color <= TRANSPARENT;
            sprite_hit   <= 1'b0;
            sprite_id    <= '0;
            DrawX_d      <= '0;
            DrawY_d      <= '0;
        end else begin
            sprite_color <= hit1_q ? rom.rom_data : TRANSPARENT;
            sprite_hit   <= hit1_q;
            sprite_id    <= id1_q;
            DrawX_d      <= x1_q;
            DrawY_d      <= y1_q;
        end
    end
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a combinational ROM model.
// ROM: bank 0 returns rom_lo, bank b returns {b, 4'hA}.
module tb_sprite_pixel_fetch;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [79:0] spr_x;
    logic [79:0] spr_y;
    logic [7:0]  spr_en;
    logic [127:0] spr_base;
`ifdef SPRITE_HFLIP_EN
    logic [7:0]  spr_flip;
`endif
    logic [7:0]  sprite_color;
    logic        sprite_hit;
    logic [2:0]  sprite_id;
    logic [9:0]  DrawX_d;
    logic [9:0]  DrawY_d;
    logic [7:0]  rom_lo;

    int n_cmp = 0;
    int n_bad = 0;

    sprite_pixel_fetch_if #(.ADDR_W(16)) rom_if ();

    assign rom_if.rom_data = (rom_if.rom_addr[15:12] == 4'h0)
                           ? rom_lo
                           : {rom_if.rom_addr[15:12], 4'hA};

    sprite_pixel_fetch dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_en       (spr_en),
        .spr_base     (spr_base),
`ifdef SPRITE_HFLIP_EN
        .spr_flip     (spr_flip),
`endif
        .rom          (rom_if),
        .sprite_color (sprite_color),
        .sprite_hit   (sprite_hit),
        .sprite_id    (sprite_id),
        .DrawX_d      (DrawX_d),
        .DrawY_d      (DrawY_d)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [9:0] x,
                            input logic [9:0] y, input logic [15:0] b,
                            input logic en);
        spr_x[10*i +: 10]  = x;
        spr_y[10*i +: 10]  = y;
        spr_base[16*i +: 16] = b;
        spr_en[i]          = en;
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        repeat (5) step();
        frame_clk = 1'b0;
        repeat (3) step();
    endtask

    task automatic pixel(input logic [9:0] x, input logic [9:0] y);
        DrawX = x;
        DrawY = y;
        step();
    endtask

    initial begin
        Reset     = 1'b1;
        frame_clk = 1'b0;
        DrawX     = '0;
        DrawY     = '0;
        spr_x     = '0;
        spr_y     = '0;
        spr_en    = '0;
        spr_base  = '0;
        rom_lo    = 8'h02;
`ifdef SPRITE_HFLIP_EN
        spr_flip  = '0;
`endif
        step();
        chk("rst_color", 32'(sprite_color), 32'h0);
        chk("rst_hit", 32'(sprite_hit), 32'h0);
        chk("rst_addr", 32'(rom_if.rom_addr), 32'h0);
        chk("rst_xd", 32'(DrawX_d), 32'h0);
        Reset = 1'b0;
        step();

        set_slot(0, 10'd100, 10'd50, 16'h0000, 1'b1);
        set_slot(2, 10'd1000, 10'd200, 16'h2000, 1'b1);
        set_slot(3, 10'd90, 10'd40, 16'h3000, 1'b1);
        frame_tick();

        pixel(10'd105, 10'd52);
        chk("basic_addr", 32'(rom_if.rom_addr), 32'h45);
        step();
        chk("basic_color", 32'(sprite_color), 32'h02);
        chk("basic_hit", 32'(sprite_hit), 32'h1);
        chk("basic_id", 32'(sprite_id), 32'h0);
        chk("basic_xd", 32'(DrawX_d), 32'd105);
        chk("basic_yd", 32'(DrawY_d), 32'd52);

        rom_lo = 8'h00;
        step();
        chk("ovl_color", 32'(sprite_color), 32'h00);
        chk("ovl_hit", 32'(sprite_hit), 32'h1);
        chk("ovl_id", 32'(sprite_id), 32'h0);

        pixel(10'd92, 10'd45);
        chk("s3_addr", 32'(rom_if.rom_addr), 32'h30A2);
        step();
        chk("s3_color", 32'(sprite_color), 32'h3A);
        chk("s3_id", 32'(sprite_id), 32'h3);

        pixel(10'd5, 10'd210);
        chk("nowrap_addr", 32'(rom_if.rom_addr), 32'h30A2);
        step();
        chk("nowrap_hit", 32'(sprite_hit), 32'h0);
        chk("nowrap_color", 32'(sprite_color), 32'h00);

        pixel(10'd1010, 10'd210);
        chk("clip_addr", 32'(rom_if.rom_addr), 32'h214A);
        step();
        chk("clip_hit", 32'(sprite_hit), 32'h1);
        chk("clip_id", 32'(sprite_id), 32'h2);
        chk("clip_color", 32'(sprite_color), 32'h2A);

        rom_lo = 8'h02;
        set_slot(0, 10'd200, 10'd50, 16'h0000, 1'b1);
        pixel(10'd105, 10'd52);
        step();
        step();
        chk("shadow_id", 32'(sprite_id), 32'h0);
        chk("shadow_color", 32'(sprite_color), 32'h02);

        frame_tick();
        pixel(10'd105, 10'd52);
        chk("latch_addr", 32'(rom_if.rom_addr), 32'h318F);
        step();
        chk("latch_id", 32'(sprite_id), 32'h3);
        chk("latch_color", 32'(sprite_color), 32'h3A);

`ifdef SPRITE_HFLIP_EN
        set_slot(0, 10'd100, 10'd50, 16'h0000, 1'b1);
        spr_flip = 8'h01;
        frame_tick();
        pixel(10'd105, 10'd52);
        chk("flip_addr", 32'(rom_if.rom_addr), 32'h5A);
        step();
        chk("flip_id", 32'(sprite_id), 32'h0);
`endif

        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        chk("mid_rst_addr", 32'(rom_if.rom_addr), 32'h0);
        chk("mid_rst_hit", 32'(sprite_hit), 32'h0);
        chk("mid_rst_color", 32'(sprite_color), 32'h0);
        chk("mid_rst_id", 32'(sprite_id), 32'h0);
        chk("mid_rst_xd", 32'(DrawX_d), 32'h0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        DrawX = 10'd321;
        DrawY = 10'd17;
        step();
        chk("post_rst_n1", 32'(DrawX_d), 32'h0);
        step();
        chk("post_rst_xd", 32'(DrawX_d), 32'd321);
        chk("post_rst_yd", 32'(DrawY_d), 32'd17);
        chk("post_rst_hit", 32'(sprite_hit), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_pixel_fetch.md
Name: sprite_pixel_fetch

Overview:
- Upstream stage of the VGA colour mapper. Per pixel, resolves which on-screen sprite (Mario, Luigi, fireballs, pipe, etc.) covers (DrawX, DrawY).
- Fetches that sprite's 8-bit palette index from a synchronous sprite ROM.
- Delivers the palette index, a hit flag and the winning sprite id, aligned with delayed pixel coordinates.
- Sprite positions are shadow-latched once per frame so a sprite never tears mid-frame.

Parameters:
- NUM_SPRITES, 8: number of sprite slots; slot 0 has the highest priority.
- SPR_W, 32: sprite width in pixels (power of two).
- SPR_H, 32: sprite height in pixels.
- ADDR_W, 16: sprite ROM address width.

Ports:
- Clk  in  1  system clock; one clock domain.
- Reset  in  1  asynchronous, active-high reset.
- frame_clk  in  1  VSYNC-derived frame tick, asynchronous to Clk.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- spr_x  in  NUM_SPRITES*10  live sprite top-left X, packed; slot i occupies bits [10i+9:10i].
- spr_y  in  NUM_SPRITES*10  live sprite top-left Y, packed the same way.
- spr_en  in  NUM_SPRITES  live per-slot enable.
- spr_base  in  NUM_SPRITES*ADDR_W  ROM base address of each slot's current frame image.
- rom_addr  out  ADDR_W  sprite ROM address.
- rom_data  in  8  ROM palette index; valid exactly 1 Clk after rom_addr.
- sprite_color  out  8  palette index; 8'h00 means transparent.
- sprite_hit  out  1  winning slot's bounding box covers the pixel.
- sprite_id  out  $clog2(NUM_SPRITES)  winning slot.
- DrawX_d  out  10  DrawX delayed to align with the outputs.
- DrawY_d  out  10  DrawY delayed to align with the outputs.

Behaviour:
- Reset (asynchronous, active-high):
  - All shadow registers, pipeline registers and outputs clear to 0; rom_addr = 0.
  - Synchroniser flops clear to 0.
  - Reset mid-frame: outputs are 0 until the next pixel has propagated.
- Frame latch:
  - frame_clk passes through a 2-flop synchroniser, then a rising-edge detector.
  - On the detected edge, spr_x, spr_y, spr_en and spr_base are copied into shadow registers.
  - The new values apply to DrawX sampled on the cycle after the edge. Pixels already in the pipeline finish with the old values.
- Stage 0 (cycle N): DrawX/DrawY are sampled.
  - Hit test for slot i: shadow_en[i] && DrawX >= x_i && DrawX < x_i+SPR_W && DrawY >= y_i && DrawY < y_i+SPR_H.
  - Sums are computed 11 bits wide, so a sprite at X = 1000 clips rather than wrapping to X = 0.
  - The lowest-index hitting slot wins.
- Stage 1 (registered at N+1):
  - Registers hit, id, dx = DrawX-x_id and dy = DrawY-y_id.
  - rom_addr = base_id + dy*SPR_W + dx, truncated to ADDR_W; it is a registered output.
  - On no hit, rom_addr holds its previous value.
- Stage 2 (registered at N+2):
  - sprite_color = rom_data if hit, else 8'h00.
  - sprite_hit, sprite_id, DrawX_d and DrawY_d are also registered.
  - Fixed latency is 2 Clk, with full throughput of one pixel per clock.
- Simultaneous hits: the priority encoder alone decides; a transparent pixel in a higher-priority sprite does not fall through to a lower one.
- Edges: pixel coordinates outside the visible area are processed normally. No handshake; the stage is free-running.

Optional Feature:
- SPRITE_HFLIP_EN defined:
  - Adds input spr_flip[NUM_SPRITES], which is shadow-latched with the other per-slot inputs.
  - When set for the winning slot, dx becomes SPR_W-1-dx before address formation.
- SPRITE_HFLIP_EN undefined: the port is absent and dx is never mirrored.

Decomposition:
- Package sprite_pkg:
  - NUM_SPRITES, SPR_W, SPR_H and ADDR_W defaults.
  - sprite_id_t.
  - TRANSPARENT = 8'h00.
  - Slot index constants: SLOT_MARIO = 0, SLOT_LUIGI = 1, etc.
- Sub-module sprite_bbox_cmp: one instance per slot, combinational 11-bit bounding-box compare returning hit, dx and dy.

Test Plan:
- Reset asserted mid-stream → all outputs 0 and rom_addr = 0 within the same cycle. After release, the first pixel's outputs appear 2 Clk later.
- Slot 0 at (100,50), base 0x0000, enabled; latched; DrawX=105, DrawY=52 → rom_addr = 0x0045 at N+1. With the ROM model returning 0x02, sprite_color = 0x02, sprite_hit = 1, id = 0, DrawX_d = 105 at N+2.
- Slots 0 and 3 overlap at the pixel, slot 0 ROM returns 0x00 → sprite_id = 0, sprite_color = 0x00, sprite_hit = 1 (no fall-through).
- Slot 2 at X = 1000; DrawX = 5, DrawY inside → sprite_hit = 0 (no wrap). DrawX = 1010 → hit with dx = 10.
- spr_x of slot 0 changes mid-frame with no frame_clk edge → output unchanged. After a frame_clk rise plus 3 Clk of synchroniser delay, the new position is used.
- SPRITE_HFLIP_EN defined, spr_flip[0] = 1, dx = 5 → rom_addr uses dx = 26.
